lipsi_loader_shell: RTL and testbench
=====================================

// Module: lipsi_loader_shell
// PURPOSE
// - Parametrised pad-side shell between the TinyTapeout pins and a Lipsi-class core.
// - Adds input synchronisers and a byte-serial program loader into the core's instruction memory.
// - Provides a registered output channel and a configurable bidirectional-pin direction mask.
// - Sits directly under tt_um_* and replaces the direct pin-to-core wiring of the first generation.
// PARAMETERS
// - DATA_W       8      data width of pins, memory bytes and output register (fixed to 8 at top).
// - ADDR_W       8      program-memory address width; memory depth is 2**ADDR_W bytes.
// - SYNC_STAGES  2      flip-flop stages on ui_in/uio_in (minimum 2).
// - RUN_OE       8'hF0  uio_oe value in RUN; bits set = output.
// PORTS
// - clock           in   1        single clock
// - reset           in   1        asynchronous, active-high reset
// - ena             in   1        high = shell enabled; low = freeze all state
// - ui_in           in   DATA_W   [0]=load strobe, [1]=mode (1 load, 0 run), [7:2] to core
// - uio_in          in   DATA_W   load data byte in LOAD; core input in RUN
// - uo_out          out  DATA_W   LOAD: ptr[7:0]; RUN: core output register
// - uio_out         out  DATA_W   RUN: core output register; LOAD: 0
// - uio_oe          out  DATA_W   LOAD: 0; RUN: RUN_OE
// - core_rst        out  1        reset to core; high in LOAD
// - core_in         out  DATA_W   synchronised {uio_in masked by ~RUN_OE}
// - core_ctrl       out  DATA_W-2 synchronised ui_in[7:2]
// - core_out        in   DATA_W   core result byte
// - core_out_valid  in   1        core_out is captured when high
// - mem_we          out  1        one-cycle instruction-memory write strobe
// - mem_addr        out  ADDR_W   write address (= ptr)
// - mem_wdata       out  DATA_W   write data
// - wrapped         out  1        sticky: ptr wrapped during the current LOAD
// BEHAVIOUR
// - Reset: state=LOAD, ptr=0, wrapped=0, out_reg=0, uo_out=0, uio_out=0, uio_oe=0, mem_we=0, core_rst=1.
// - Reset is asynchronous; asserting it mid-operation aborts any write in the same cycle (mem_we=0).
// - Sync path: ui_in and uio_in each pass SYNC_STAGES flops.
// - Edge detect: strobe_rise = s_strobe & ~s_strobe_d.
// - Load write: mem_we pulses in the cycle after strobe_rise is detected.
//   - Total latency: SYNC_STAGES+1 clocks from the first clock edge sampling ui_in[0]=1.
//   - mem_addr=ptr and mem_wdata=synchronised uio_in, both sampled with the strobe.
// - Strobe held high gives exactly one write; strobe pulses shorter than 1 clock are not guaranteed.
// - ptr increments after each write; at 2**ADDR_W-1 it wraps to 0 and sets wrapped.
// - FSM LOAD -> RUN: when s_mode=0.
//   - core_rst drops the next cycle; ptr and wrapped clear.
//   - A strobe edge coinciding with the mode change is ignored (no write).
// - FSM RUN -> LOAD: when s_mode=1.
//   - core_rst rises the next cycle; out_reg holds; uio_oe=0 the same cycle as core_rst.
// - In RUN, out_reg <= core_out on core_out_valid; otherwise it holds.
// - In RUN, uo_out = uio_out = out_reg.
// - ena=0: no state, ptr, out_reg or synchroniser change; mem_we=0; outputs hold their last values.
// - All outputs are registered except core_in and core_ctrl, which come from the synchroniser tail.
// TESTING
// - Reset: after reset, check core_rst=1, uio_oe=0, uo_out=0, mem_we=0, and that nothing happens
//   without a strobe.
// - Load 3 bytes: uio_in=8'hA1,8'hB2,8'hC3 with a strobe each; expect exactly 3 mem_we pulses at
//   addr 0,1,2 with matching data, each SYNC_STAGES+1 clocks after its strobe; uo_out=3 afterwards.
// - Wrap (ADDR_W=4): 17 strobes; expect write 17 at addr 0 and wrapped=1; uo_out=1.
// - Run: mode 1->0, then core_out_valid with core_out=8'h5A; expect core_rst=0, uio_oe=8'hF0, and
//   uo_out=uio_out=8'h5A one clock after valid.
// - ena freeze: ena=0 with a strobe pulse; expect no mem_we and ptr unchanged; after ena=1 with
//   the strobe low, expect no write.
// - Mid-load reset: assert reset while a strobe is in the synchroniser; expect mem_we=0 and ptr=0,
//   with no write after release.

Source files
------------

// File: rtl/lipsi_loader_shell.sv
// Pad-side shell for a Lipsi-class core: pin synchronisers, byte-serial program
// loader into instruction memory, registered output channel and uio direction control.
module lipsi_loader_shell #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RUN_OE      = 8'hF0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ena,
    input  logic [DATA_W-1:0] ui_in,
    input  logic [DATA_W-1:0] uio_in,
    output logic [DATA_W-1:0] uo_out,
    output logic [DATA_W-1:0] uio_out,
    output logic [DATA_W-1:0] uio_oe,
    output logic              core_rst,
    output logic [DATA_W-1:0] core_in,
    output logic [DATA_W-3:0] core_ctrl,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_out_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              wrapped
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ui_sync_q  [SYNC_STAGES];
    logic [DATA_W-1:0] ui_sync_d  [SYNC_STAGES];
    logic [DATA_W-1:0] uio_sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] uio_sync_d [SYNC_STAGES];
    logic              strobe_dly_q, strobe_dly_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrapped_q, wrapped_d;
    logic [DATA_W-1:0] out_reg_q, out_reg_d;
    logic [DATA_W-1:0] uo_out_q, uo_out_d;
    logic [DATA_W-1:0] uio_out_q, uio_out_d;
    logic [DATA_W-1:0] uio_oe_q, uio_oe_d;
    logic              core_rst_q, core_rst_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0] s_ui, s_uio;
    logic              s_strobe, s_mode, strobe_rise;

    assign s_ui        = ui_sync_q[SYNC_STAGES-1];
    assign s_uio       = uio_sync_q[SYNC_STAGES-1];
    assign s_strobe    = s_ui[0];
    assign s_mode      = s_ui[1];
    assign strobe_rise = s_strobe & ~strobe_dly_q;

    always_comb begin
        state_d      = state_q;
        ui_sync_d    = ui_sync_q;
        uio_sync_d   = uio_sync_q;
        strobe_dly_d = strobe_dly_q;
        ptr_d        = ptr_q;
        wrapped_d    = wrapped_q;
        out_reg_d    = out_reg_q;
        uo_out_d     = uo_out_q;
        uio_out_d    = uio_out_q;
        uio_oe_d     = uio_oe_q;
        core_rst_d   = core_rst_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (ena) begin
            ui_sync_d[0]  = ui_in;
            uio_sync_d[0] = uio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ui_sync_d[i]  = ui_sync_q[i-1];
                uio_sync_d[i] = uio_sync_q[i-1];
            end
            strobe_dly_d = s_strobe;

            case (state_q)
                ST_LOAD: begin
                    // Leaving LOAD takes priority: a strobe edge in the same cycle is dropped.
                    if (!s_mode) begin
                        state_d   = ST_RUN;
                        ptr_d     = '0;
                        wrapped_d = 1'b0;
                    end else if (strobe_rise) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = s_uio;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        if (ptr_q == {ADDR_W{1'b1}}) begin
                            wrapped_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (s_mode) begin
                        state_d = ST_LOAD;
                    end else if (core_out_valid) begin
                        out_reg_d = core_out;
                    end
                end
            endcase

            // Pin outputs follow the next state so they change together with core_rst.
            if (state_d == ST_LOAD) begin
                uo_out_d   = DATA_W'(ptr_d);
                uio_out_d  = '0;
                uio_oe_d   = '0;
                core_rst_d = 1'b1;
            end else begin
                uo_out_d   = out_reg_d;
                uio_out_d  = out_reg_d;
                uio_oe_d   = RUN_OE;
                core_rst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ui_sync_q[i]  <= '0;
                uio_sync_q[i] <= '0;
            end
            strobe_dly_q <= 1'b0;
            ptr_q        <= '0;
            wrapped_q    <= 1'b0;
            out_reg_q    <= '0;
            uo_out_q     <= '0;
            uio_out_q    <= '0;
            uio_oe_q     <= '0;
            core_rst_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ui_sync_q[i]  <= ui_sync_d[i];
                uio_sync_q[i] <= uio_sync_d[i];
            end
            strobe_dly_q <= strobe_dly_d;
            ptr_q        <= ptr_d;
            wrapped_q    <= wrapped_d;
            out_reg_q    <= out_reg_d;
            uo_out_q     <= uo_out_d;
            uio_out_q    <= uio_out_d;
            uio_oe_q     <= uio_oe_d;
            core_rst_q   <= core_rst_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign uo_out    = uo_out_q;
    assign uio_out   = uio_out_q;
    assign uio_oe    = uio_oe_q;
    assign core_rst  = core_rst_q;
    assign core_in   = s_uio & ~RUN_OE;
    assign core_ctrl = s_ui[DATA_W-1:2];
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_lipsi_loader_shell.sv
// Scoreboard bench for lipsi_loader_shell with a 16-byte program memory.
module tb_lipsi_loader_shell;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ena = 1'b1;
    logic [DATA_W-1:0] ui_in = 8'h02;
    logic [DATA_W-1:0] uio_in = '0;
    logic [DATA_W-1:0] uo_out, uio_out, uio_oe, core_in;
    logic [DATA_W-3:0] core_ctrl;
    logic              core_rst, mem_we, wrapped;
    logic [DATA_W-1:0] core_out = '0;
    logic              core_out_valid = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   exp_ptr = 0;

    lipsi_loader_shell #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES), .RUN_OE(8'hF0)
    ) dut (
        .clock(clock), .reset(reset), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .core_rst(core_rst),
        .core_in(core_in), .core_ctrl(core_ctrl), .core_out(core_out),
        .core_out_valid(core_out_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .wrapped(wrapped)
    );

    always #5 clock = ~clock;

    // Advance n clocks; every write seen on the way is checked against the scoreboard.
    task automatic tick(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            cyc++;
            if (mem_we === 1'b1) begin
                wr_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0h data=%0h at cycle %0d, none expected",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    e = sb.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.due) begin
                        errors++;
                        $display("FAIL write: addr=%0h data=%0h cycle=%0d, required addr=%0h data=%0h cycle=%0d",
                                 mem_addr, mem_wdata, cyc, e.addr, e.data, e.due);
                    end
                end
            end
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        sb.delete();
        exp_ptr = 0;
        tick(1);
    endtask

    task automatic load_byte(input logic [DATA_W-1:0] d);
        exp_t e;
        uio_in   = d;
        ui_in[0] = 1'b1;
        e.addr = ADDR_W'(exp_ptr);
        e.data = d;
        e.due  = cyc + SYNC_STAGES + 1;
        sb.push_back(e);
        exp_ptr = (exp_ptr + 1) % (1 << ADDR_W);
        tick(3);
        ui_in[0] = 1'b0;
        tick(4);
    endtask

    task automatic drain_check(input string name);
        tick(SYNC_STAGES + 3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d writes still outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ui_in = 8'h02;
        tick(2);
        checks++;
        if (core_rst !== 1'b1 || uio_oe !== 8'h00 || uo_out !== 8'h00 || uio_out !== 8'h00 ||
            mem_we !== 1'b0 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: core_rst=%b uio_oe=%h uo_out=%h uio_out=%h mem_we=%b wrapped=%b, required 1 00 00 00 0 0",
                     core_rst, uio_oe, uo_out, uio_out, mem_we, wrapped);
        end
        reset = 1'b0;
        sb.delete();
        exp_ptr = 0;
        wr_count = 0;
        tick(6);
        checks++;
        if (wr_count != 0 || uo_out !== 8'h00 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: writes=%0d uo_out=%h core_rst=%b, required 0 00 1",
                     wr_count, uo_out, core_rst);
        end
    endtask

    task automatic test_load3();
        int w0;
        do_reset();
        w0 = wr_count;
        load_byte(8'hA1);
        load_byte(8'hB2);
        load_byte(8'hC3);
        drain_check("load3");
        checks++;
        if (wr_count - w0 != 3 || uo_out !== 8'h03 || wrapped !== 1'b0) begin
            errors++;
            $display("FAIL load3: writes=%0d uo_out=%h wrapped=%b, required 3 03 0",
                     wr_count - w0, uo_out, wrapped);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) load_byte(8'(8'h10 + i));
        checks++;
        if (wrapped !== 1'b0 || uo_out !== 8'h0F) begin
            errors++;
            $display("FAIL wrap_before: wrapped=%b uo_out=%h, required 0 0f", wrapped, uo_out);
        end
        load_byte(8'h1F);
        load_byte(8'h20);
        drain_check("wrap");
        checks++;
        if (wrapped !== 1'b1 || uo_out !== 8'h01) begin
            errors++;
            $display("FAIL wrap_after: wrapped=%b uo_out=%h, required 1 01", wrapped, uo_out);
        end
    endtask

    task automatic test_run();
        uio_in = 8'hFF;
        ui_in  = {6'h2A, 2'b00};
        tick(SYNC_STAGES + 2);
        checks++;
        if (core_rst !== 1'b0 || uio_oe !== 8'hF0 || wrapped !== 1'b0 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL run_enter: core_rst=%b uio_oe=%h wrapped=%b uo_out=%h, required 0 f0 0 00",
                     core_rst, uio_oe, wrapped, uo_out);
        end
        checks++;
        if (core_in !== 8'h0F || core_ctrl !== 6'h2A) begin
            errors++;
            $display("FAIL run_sync: core_in=%h core_ctrl=%h, required 0f 2a", core_in, core_ctrl);
        end
        core_out = 8'h5A;
        core_out_valid = 1'b1;
        tick(1);
        core_out_valid = 1'b0;
        core_out = 8'h77;
        checks++;
        if (uo_out !== 8'h5A || uio_out !== 8'h5A) begin
            errors++;
            $display("FAIL run_capture: uo_out=%h uio_out=%h, required 5a 5a", uo_out, uio_out);
        end
        tick(3);
        checks++;
        if (uo_out !== 8'h5A || uio_out !== 8'h5A) begin
            errors++;
            $display("FAIL run_hold: uo_out=%h uio_out=%h, required 5a 5a", uo_out, uio_out);
        end
        ui_in = 8'h02;
        uio_in = 8'h00;
        tick(SYNC_STAGES + 1);
        checks++;
        if (core_rst !== 1'b1 || uio_oe !== 8'h00 || uio_out !== 8'h00 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL run_exit: core_rst=%b uio_oe=%h uio_out=%h uo_out=%h, required 1 00 00 00",
                     core_rst, uio_oe, uio_out, uo_out);
        end
        exp_ptr = 0;
    endtask

    task automatic test_ena_freeze();
        int w0;
        do_reset();
        load_byte(8'h3C);
        drain_check("freeze_pre");
        w0 = wr_count;
        ena = 1'b0;
        uio_in = 8'hEE;
        ui_in[0] = 1'b1;
        tick(3);
        ui_in[0] = 1'b0;
        tick(3);
        checks++;
        if (wr_count != w0 || uo_out !== 8'h01 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL freeze_hold: writes=%0d uo_out=%h core_rst=%b, required 0 01 1",
                     wr_count - w0, uo_out, core_rst);
        end
        ena = 1'b1;
        tick(SYNC_STAGES + 4);
        checks++;
        if (wr_count != w0 || uo_out !== 8'h01) begin
            errors++;
            $display("FAIL freeze_release: writes=%0d uo_out=%h, required 0 01", wr_count - w0, uo_out);
        end
    endtask

    task automatic test_midload_reset();
        int w0;
        do_reset();
        load_byte(8'h55);
        drain_check("midreset_pre");
        w0 = wr_count;
        uio_in = 8'h99;
        ui_in[0] = 1'b1;
        tick(1);
        reset = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || uo_out !== 8'h00 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL midreset_assert: mem_we=%b uo_out=%h core_rst=%b, required 0 00 1",
                     mem_we, uo_out, core_rst);
        end
        tick(2);
        ui_in[0] = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(SYNC_STAGES + 4);
        checks++;
        if (wr_count != w0 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL midreset_release: writes=%0d uo_out=%h, required 0 00", wr_count - w0, uo_out);
        end
    endtask

    initial begin
        test_reset();
        test_load3();
        test_wrap();
        test_run();
        test_ena_freeze();
        test_midload_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
